// File: rtl/manhattan_update_engine_pkg.sv
// Shared word format for the Manhattan update engine: FloPoCo float is
// {exception[1:0], sign, exponent, mantissa}, single-precision payload.
package manhattan_update_engine_pkg;

    localparam int FP_BW    = 32;
    localparam int FP_EXTRA = 2;
    localparam int WW       = FP_BW + FP_EXTRA;
    localparam int EXP_W    = 8;
    localparam int MAN_W    = FP_BW - 1 - EXP_W;

    localparam int EXC_HI   = WW - 1;
    localparam int EXC_LO   = FP_BW;
    localparam int SIGN_BIT = FP_BW - 1;
    localparam int EXP_HI   = FP_BW - 2;
    localparam int EXP_LO   = MAN_W;
    localparam int MAN_HI   = MAN_W - 1;

    localparam logic [WW-1:0] FP_ZERO    = '0;
    localparam logic [1:0]    EXC_ZERO   = 2'b00;
    localparam logic [1:0]    EXC_NORMAL = 2'b01;
    localparam logic [1:0]    EXC_INF    = 2'b10;
    localparam logic [1:0]    EXC_NAN    = 2'b11;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_DONE} sweep_state_t;

endpackage

// File: rtl/manhattan_update_engine_fp_add_pipe.sv
// FloPoCo-format adder (round-to-nearest-even, no subnormals) followed by
// ADD_LATENCY register stages; a sideband word and valid bit ride alongside.
module fp_add_pipe
    import manhattan_update_engine_pkg::*;
#(
    parameter int ADD_LATENCY = 2,
    parameter int SIDE_W      = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld,
    input  logic [WW-1:0]     a,
    input  logic [WW-1:0]     b,
    input  logic [SIDE_W-1:0] side_in,
    output logic              out_vld,
    output logic [WW-1:0]     sum,
    output logic [SIDE_W-1:0] side_out
);

    localparam int FW = MAN_W + 4;

    function automatic logic [WW-1:0] round_pack(input logic sign, input logic [EXP_W+1:0] exp_in,
                                                 input logic [FW-1:0] m);
        logic [MAN_W+1:0] mr;
        logic [EXP_W+1:0] e;
        logic             up;
        up = m[2] & (m[1] | m[0] | m[3]);
        mr = {1'b0, m[FW-1:3]} + (MAN_W+2)'(up);
        e  = exp_in;
        if (mr[MAN_W+1]) begin
            mr = mr >> 1;
            e  = e + (EXP_W+2)'(1);
        end
        if (e[EXP_W+1])
            return {EXC_ZERO, sign, {(FP_BW-1){1'b0}}};
        if (e[EXP_W])
            return {EXC_INF, sign, {(FP_BW-1){1'b0}}};
        return {EXC_NORMAL, sign, e[EXP_W-1:0], mr[MAN_W-1:0]};
    endfunction

    function automatic logic [WW-1:0] fp_add(input logic [WW-1:0] x, input logic [WW-1:0] y);
        logic [1:0]       xa, xb;
        logic [WW-1:0]    big, sml;
        logic [EXP_W-1:0] d;
        logic [FW-1:0]    mb, ms, ms_sh, m;
        logic [FW:0]      acc;
        logic [EXP_W+1:0] e;
        logic             found;
        int               lz;
        xa = x[EXC_HI:EXC_LO];
        xb = y[EXC_HI:EXC_LO];
        if (xa == EXC_NAN || xb == EXC_NAN ||
            (xa == EXC_INF && xb == EXC_INF && x[SIGN_BIT] != y[SIGN_BIT]))
            return {EXC_NAN, {FP_BW{1'b0}}};
        if (xa == EXC_INF) return x;
        if (xb == EXC_INF) return y;
        if (xa == EXC_ZERO)
            return (xb == EXC_ZERO) ? {EXC_ZERO, x[SIGN_BIT] & y[SIGN_BIT], {(FP_BW-1){1'b0}}} : y;
        if (xb == EXC_ZERO) return x;
        if (x[SIGN_BIT-1:0] >= y[SIGN_BIT-1:0]) begin
            big = x; sml = y;
        end else begin
            big = y; sml = x;
        end
        d     = big[EXP_HI:EXP_LO] - sml[EXP_HI:EXP_LO];
        mb    = {1'b1, big[MAN_HI:0], 3'b000};
        ms    = {1'b1, sml[MAN_HI:0], 3'b000};
        // Bits shifted out collapse into the sticky position
        ms_sh = (ms >> d) | FW'(|(ms & ~({FW{1'b1}} << d)));
        e     = {2'b00, big[EXP_HI:EXP_LO]};
        if (big[SIGN_BIT] == sml[SIGN_BIT]) begin
            acc = {1'b0, mb} + {1'b0, ms_sh};
            if (acc[FW]) begin
                m = acc[FW:1] | FW'(acc[0]);
                e = e + (EXP_W+2)'(1);
            end else begin
                m = acc[FW-1:0];
            end
        end else begin
            acc = {1'b0, mb} - {1'b0, ms_sh};
            if (acc == '0) return FP_ZERO;
            lz    = 0;
            found = 1'b0;
            for (int i = FW - 1; i >= 0; i--) begin
                if (!found) begin
                    if (acc[i]) found = 1'b1;
                    else        lz = lz + 1;
                end
            end
            m = acc[FW-1:0] << lz;
            e = e - (EXP_W+2)'(lz);
        end
        return round_pack(big[SIGN_BIT], e, m);
    endfunction

    logic [WW-1:0] sum_c;
    assign sum_c = fp_add(a, b);

    generate
        if (ADD_LATENCY == 0) begin : g_comb
            assign sum      = sum_c;
            assign side_out = side_in;
            assign out_vld  = in_vld;
        end else begin : g_pipe
            logic [WW-1:0]          sum_p  [ADD_LATENCY];
            logic [SIDE_W-1:0]      side_p [ADD_LATENCY];
            logic [ADD_LATENCY-1:0] vld_p;

            always_ff @(posedge clk) begin
                sum_p[0]  <= sum_c;
                side_p[0] <= side_in;
                for (int i = 1; i < ADD_LATENCY; i++) begin
                    sum_p[i]  <= sum_p[i-1];
                    side_p[i] <= side_p[i-1];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_p <= '0;
                end else begin
                    vld_p[0] <= in_vld;
                    for (int i = 1; i < ADD_LATENCY; i++) vld_p[i] <= vld_p[i-1];
                end
            end

            assign sum      = sum_p[ADD_LATENCY-1];
            assign side_out = side_p[ADD_LATENCY-1];
            assign out_vld  = vld_p[ADD_LATENCY-1];
        end
    endgenerate

endmodule

// File: rtl/manhattan_update_engine.sv
// Sequential Manhattan updater: W[k] <= W[k] + eta*sgn(E[k]) over a memory sweep.
// Optional MANHATTAN_CLAMP_EN saturates results to +/-WEIGHT_LIMIT.
module manhattan_update_engine
    import manhattan_update_engine_pkg::*;
#(
    parameter int BIT_WIDTH   = 32,
    parameter int EXTRA_BIT   = 2,
    parameter int NUM_WEIGHTS = 8,
    parameter int ADD_LATENCY = 2,
    parameter int AW          = (NUM_WEIGHTS > 1) ? $clog2(NUM_WEIGHTS) : 1
`ifdef MANHATTAN_CLAMP_EN
    ,
    parameter logic [BIT_WIDTH+EXTRA_BIT-1:0] WEIGHT_LIMIT = {EXC_NORMAL, 32'h3F80_0000}
`endif
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [BIT_WIDTH+EXTRA_BIT-1:0] eta,
    output logic                           busy,
    output logic                           done,
    output logic                           rd_en,
    output logic [AW-1:0]                  rd_addr,
    input  logic [BIT_WIDTH+EXTRA_BIT-1:0] rd_weight,
    input  logic [BIT_WIDTH+EXTRA_BIT-1:0] rd_error,
    output logic                           wr_en,
    output logic [AW-1:0]                  wr_addr,
    output logic [BIT_WIDTH+EXTRA_BIT-1:0] wr_data,
    output logic [AW:0]                    updated_count
);

    localparam logic [AW-1:0] LAST   = AW'(NUM_WEIGHTS - 1);
    localparam int            SIDE_W = AW + WW + 2;

`ifdef MANHATTAN_CLAMP_EN
    function automatic logic [WW-1:0] saturate(input logic [WW-1:0] v);
        if (v[EXC_HI:EXC_LO] == EXC_NORMAL && v[SIGN_BIT-1:0] > WEIGHT_LIMIT[SIGN_BIT-1:0])
            return {WEIGHT_LIMIT[EXC_HI:EXC_LO], v[SIGN_BIT], WEIGHT_LIMIT[SIGN_BIT-1:0]};
        return v;
    endfunction
`else
    function automatic logic [WW-1:0] saturate(input logic [WW-1:0] v);
        return v;
    endfunction
`endif

    sweep_state_t      state, state_nx;
    logic              accept;
    logic [AW-1:0]     cnt;
    logic [WW-1:0]     eta_q;
    logic              vld_p0;
    logic [AW-1:0]     addr_p0;
    logic [WW-1:0]     delta_p0;
    logic              zero_p0, cancel_p0;
    logic [SIDE_W-1:0] side_p0, side_o;
    logic              vld_o;
    logic [WW-1:0]     sum_o, old_o, result_o;
    logic [AW-1:0]     addr_o;
    logic              zero_o, cancel_o;
    logic              err_mag_unused;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            vld_p0 <= 1'b0;
        end else begin
            state  <= state_nx;
            vld_p0 <= rd_en;
            if (state == ST_ISSUE) cnt <= (cnt == LAST) ? '0 : cnt + AW'(1);
        end
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        busy     = (state != ST_IDLE);
        done     = 1'b0;
        rd_en    = 1'b0;
        rd_addr  = cnt;
        case (state)
            ST_IDLE:  if (start) begin
                          state_nx = ST_ISSUE;
                          accept   = 1'b1;
                      end
            ST_ISSUE: begin
                          rd_en = 1'b1;
                          if (cnt == LAST) state_nx = ST_DRAIN;
                      end
            ST_DRAIN: if (wr_en && wr_addr == LAST) state_nx = ST_DONE;
            ST_DONE:  begin
                          done     = 1'b1;
                          state_nx = ST_IDLE;
                      end
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) eta_q <= eta;
        addr_p0 <= rd_addr;
    end

    // p0: read data returns; form delta and the bypass flags
    assign err_mag_unused = ^rd_error[SIGN_BIT-1:0];
    assign delta_p0  = {eta_q[EXC_HI:EXC_LO], rd_error[SIGN_BIT], eta_q[SIGN_BIT-1:0]};
    assign zero_p0   = (rd_error[EXC_HI:EXC_LO] == EXC_ZERO);
    assign cancel_p0 = !zero_p0
                    && rd_weight[EXC_HI:EXC_LO] == delta_p0[EXC_HI:EXC_LO]
                    && rd_weight[SIGN_BIT-1:0]  == delta_p0[SIGN_BIT-1:0]
                    && rd_weight[SIGN_BIT]      != delta_p0[SIGN_BIT];
    assign side_p0   = {addr_p0, rd_weight, zero_p0, cancel_p0};

    fp_add_pipe #(
        .ADD_LATENCY (ADD_LATENCY),
        .SIDE_W      (SIDE_W)
    ) u_add (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (vld_p0),
        .a        (rd_weight),
        .b        (delta_p0),
        .side_in  (side_p0),
        .out_vld  (vld_o),
        .sum      (sum_o),
        .side_out (side_o)
    );

    // Adder output stage: select, saturate and register the write
    assign {addr_o, old_o, zero_o, cancel_o} = side_o;

    always_comb begin
        result_o = saturate(sum_o);
        if (zero_o)        result_o = old_o;
        else if (cancel_o) result_o = FP_ZERO;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en         <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= '0;
            updated_count <= '0;
        end else begin
            wr_en <= vld_o;
            if (accept) updated_count <= '0;
            if (vld_o) begin
                wr_addr <= addr_o;
                wr_data <= result_o;
                if (result_o != old_o) updated_count <= updated_count + (AW+1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_manhattan_update_engine.sv
// Directed bench for manhattan_update_engine: table-driven sweeps against a
// simple read-only memory model, plus reset and abort sequences.
module tb_manhattan_update_engine;
    import manhattan_update_engine_pkg::*;

    localparam int N   = 4;
    localparam int LAT = 2;
    localparam int AW  = 2;

    localparam logic [WW-1:0] F_ZERO_ERR = {2'b00, 32'h0000_0000};
    localparam logic [WW-1:0] F_HALF     = {2'b01, 32'h3F00_0000};
    localparam logic [WW-1:0] F_MHALF    = {2'b01, 32'hBF00_0000};
    localparam logic [WW-1:0] F_0_75     = {2'b01, 32'h3F40_0000};
    localparam logic [WW-1:0] F_M0_75    = {2'b01, 32'hBF40_0000};
    localparam logic [WW-1:0] F_ONE      = {2'b01, 32'h3F80_0000};
    localparam logic [WW-1:0] F_MONE     = {2'b01, 32'hBF80_0000};
    localparam logic [WW-1:0] F_1_25     = {2'b01, 32'h3FA0_0000};
    localparam logic [WW-1:0] F_M1_25    = {2'b01, 32'hBFA0_0000};
    localparam logic [WW-1:0] F_1_5      = {2'b01, 32'h3FC0_0000};
    localparam logic [WW-1:0] F_TWO      = {2'b01, 32'h4000_0000};
    localparam logic [WW-1:0] F_M3       = {2'b01, 32'hC040_0000};
`ifdef MANHATTAN_CLAMP_EN
    localparam logic [WW-1:0] C_POS = F_ONE;
    localparam logic [WW-1:0] C_NEG = F_MONE;
`else
    localparam logic [WW-1:0] C_POS = F_1_25;
    localparam logic [WW-1:0] C_NEG = F_M1_25;
`endif

    logic          clk = 1'b0;
    logic          rst, start, busy, done, rd_en, wr_en;
    logic [WW-1:0] eta, rd_weight, rd_error, wr_data;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [AW:0]   updated_count;

    always #5 clk = ~clk;

    manhattan_update_engine #(
        .NUM_WEIGHTS (N),
        .ADD_LATENCY (LAT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .eta           (eta),
        .busy          (busy),
        .done          (done),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_weight     (rd_weight),
        .rd_error      (rd_error),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .updated_count (updated_count)
    );

    logic [WW-1:0] wmem [N];
    logic [WW-1:0] emem [N];

    always @(posedge clk) begin
        if (rd_en) begin
            rd_weight <= wmem[rd_addr];
            rd_error  <= emem[rd_addr];
        end
    end

    typedef struct {
        logic [WW-1:0] w;
        logic [WW-1:0] e;
        logic [WW-1:0] exp;
    } vec_t;

    vec_t vecs [3*N];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic load(input int sid);
        for (int k = 0; k < N; k++) begin
            wmem[k] = vecs[sid*N+k].w;
            emem[k] = vecs[sid*N+k].e;
        end
    endtask

    task automatic run_sweep(input int sid, input logic [WW-1:0] eta_v, input int exp_cnt,
                             input bit disturb);
        int cyc, nwr, ndone;
        load(sid);
        start = 1'b1;
        eta   = eta_v;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 1;
        nwr   = 0;
        ndone = 0;
        check("busy_after_start", 64'(busy), 64'(1));
        check("rd_first", 64'({rd_en, rd_addr}), 64'({1'b1, 2'd0}));
        while (cyc < 40 && ndone == 0) begin
            if (wr_en) begin
                check("wr_addr", 64'(wr_addr), 64'(nwr));
                check("wr_cycle", 64'(cyc), 64'(nwr + 3 + LAT));
                if (nwr < N) check("wr_data", 64'(wr_data), 64'(vecs[sid*N+nwr].exp));
                nwr++;
            end
            if (cyc == N) check("rd_last", 64'({rd_en, rd_addr}), 64'({1'b1, 2'(N-1)}));
            if (done) begin
                check("done_cycle", 64'(cyc), 64'(N + 3 + LAT));
                ndone++;
            end
            if (disturb) begin
                start = (cyc == 3);
                if (cyc == 2) eta = F_TWO;
            end
            if (ndone == 0) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        start = 1'b0;
        check("done_seen", 64'(ndone), 64'(1));
        check("write_count", 64'(nwr), 64'(N));
        check("updated_count", 64'(updated_count), 64'(exp_cnt));
        @(posedge clk); #1;
        check("done_pulse_end", 64'({done, busy, wr_en}), 64'(0));
        check("count_stable", 64'(updated_count), 64'(exp_cnt));
    endtask

    task automatic reset_abort();
        int seen_wr, seen_done;
        seen_wr   = 0;
        seen_done = 0;
        load(1);
        start = 1'b1;
        eta   = F_HALF;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("busy_before_abort", 64'(busy), 64'(1));
        rst = 1'b1;
        #1;
        check("abort_ctrl", 64'({busy, done, rd_en, wr_en}), 64'(0));
        check("abort_addr", 64'({rd_addr, wr_addr}), 64'(0));
        check("abort_data", 64'(wr_data), 64'(0));
        check("abort_count", 64'(updated_count), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (wr_en) seen_wr++;
            if (done)  seen_done++;
        end
        check("abort_no_write", 64'(seen_wr), 64'(0));
        check("abort_no_done", 64'(seen_done), 64'(0));
        check("abort_idle", 64'(busy), 64'(0));
    endtask

    initial begin
        // Sweep 0: test-plan vectors (normal, negative step, cancel, zero error)
        vecs[0]  = '{F_ONE,   F_TWO,      F_1_5};
        vecs[1]  = '{F_ONE,   F_M3,       F_HALF};
        vecs[2]  = '{F_HALF,  F_MONE,     FP_ZERO};
        vecs[3]  = '{F_0_75,  F_ZERO_ERR, F_0_75};
        // Sweep 1: every error non-zero, mixed signs and exponent gaps
        vecs[4]  = '{F_ONE,   F_TWO,      F_1_5};
        vecs[5]  = '{F_TWO,   F_MONE,     F_1_5};
        vecs[6]  = '{F_MONE,  F_ONE,      F_MHALF};
        vecs[7]  = '{F_ONE,   F_M3,       F_HALF};
        // Sweep 2: results around the clamp limit
        vecs[8]  = '{F_0_75,  F_ONE,      C_POS};
        vecs[9]  = '{F_M0_75, F_MONE,     C_NEG};
        vecs[10] = '{F_HALF,  F_ONE,      F_ONE};
        vecs[11] = '{F_ONE,   F_MONE,     F_HALF};

        rst   = 1'b1;
        start = 1'b0;
        eta   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", 64'({busy, done, rd_en, wr_en}), 64'(0));
        check("reset_addr", 64'({rd_addr, wr_addr}), 64'(0));
        check("reset_data", 64'(wr_data), 64'(0));
        check("reset_count", 64'(updated_count), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        run_sweep(0, F_HALF, 3, 1'b1);
        run_sweep(1, F_HALF, 4, 1'b0);
        run_sweep(2, F_HALF, 4, 1'b0);
        reset_abort();
        run_sweep(1, F_HALF, 4, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/manhattan_update_engine.md
Name: manhattan_update_engine

Overview:
- Sequential, memory-backed Manhattan weight updater. For each weight k in 0..NUM_WEIGHTS-1 it computes W[k] <= W[k] + eta*sgn(E[k]).
- Reads old weights and differentiated errors through a synchronous read port and writes updated weights back through a write port.
- A single pipelined FloPoCo adder is shared across all weights, one weight issued per cycle.
- Sits between the error back-propagation stage and the weight memory. Replaces per-weight combinational updater instances.

Parameters:
- BIT_WIDTH, 32: IEEE-754 payload width.
- EXTRA_BIT, 2: FloPoCo exception bits. Word width is WW = BIT_WIDTH+EXTRA_BIT.
- NUM_WEIGHTS, 8: number of weights per sweep; must be >= 1.
- ADD_LATENCY, 2: register stages inside the adder; 0 is legal.
- AW, $clog2(NUM_WEIGHTS) (minimum 1): address width.

Ports:
- clk, input, 1: clock.
- rst, input, 1: asynchronous active-high reset.
- start, input, 1: one-cycle sweep request; sampled only in IDLE.
- eta, input, WW: step size; latched on an accepted start.
- busy, output, 1: high from the accepted start until done.
- done, output, 1: one-cycle pulse at the end of a sweep.
- rd_en, output, 1: read strobe.
- rd_addr, output, AW: read address.
- rd_weight, input, WW: old weight, valid 1 cycle after rd_en.
- rd_error, input, WW: differentiated error, valid 1 cycle after rd_en.
- wr_en, output, 1: write strobe.
- wr_addr, output, AW: write address.
- wr_data, output, WW: updated weight.
- updated_count, output, AW+1: number of weights whose value changed in the last sweep.

Behaviour:
- Reset values: busy=0, done=0, rd_en=0, wr_en=0, rd_addr=0, wr_addr=0, wr_data=0, updated_count=0. FSM goes to IDLE. The pipeline valid bits clear, so no write is emitted after reset.
- FSM states:
  - IDLE -> ISSUE on start. eta is latched and updated_count clears.
  - ISSUE asserts rd_en for NUM_WEIGHTS consecutive cycles with rd_addr 0,1,..,N-1, then moves to DRAIN.
  - DRAIN waits until the last write has been emitted, then moves to DONE.
  - DONE pulses done=1 for one cycle and returns to IDLE.
- start while busy is ignored. eta changes during a sweep have no effect.
- Timing, with the accepted start in cycle 0:
  - read of weight k in cycle k+1;
  - wr_en for weight k in cycle k+3+ADD_LATENCY, with wr_addr=k;
  - done in cycle N+3+ADD_LATENCY.
- Delta: equals the latched eta with its sign bit (bit BIT_WIDTH-1) replaced by the error sign bit. No multiplier is used.
- Zero error: error exception bits == 2'b00 means no update. wr_data = old weight, and the weight is not counted in updated_count.
- Exact cancellation: when the old weight equals -delta (same exception, exponent and mantissa, opposite sign), wr_data = all-zero WW. This suppresses FloPoCo residue.
- Normal case: wr_data = adder result.
- updated_count increments once per written weight whose wr_data differs from its old weight. Its final value is stable from done until the next accepted start.
- Bypass registers carry the old weight, the zero flag and the cancel flag alongside the adder pipeline, so they stay aligned with the adder output.
- Reset mid-sweep aborts immediately. Partially written memory contents are left as they are.

Optional Feature:
- Macro: MANHATTAN_CLAMP_EN.
- With the macro defined: adds a parameter WEIGHT_LIMIT (WW, default 1.0). Any result whose magnitude (bits BIT_WIDTH-2:0, compared unsigned, exception 01) exceeds the limit is replaced by the limit with the result's sign. Clamping adds no latency.
- Without the macro: no comparator and no parameter; the result passes unchanged.

Decomposition:
- Shared package contains:
  - WW;
  - field-index constants for the exception, sign, exponent and mantissa positions;
  - FP_ZERO (all-zero WW);
  - EXC_NORMAL = 2'b01.
- One sub-module, fp_add_pipe: wraps the combinational FloPoCo adder with ADD_LATENCY output register stages and a matching valid shift chain.

Test Plan:
- N=4, ADD_LATENCY=2, eta=0.5, W0=1.0, E0=+2.0 -> wr_data=1.5 ({01,0x3FC00000}) at addr 0 in cycle 5; done in cycle 9; updated_count=4 when all errors are non-zero.
- W1=1.0, E1=-3.0 -> wr_data=0.5 ({01,0x3F000000}).
- W2=0.5, E2=-1.0 -> wr_data=34'b0 exactly, and the weight is counted as updated.
- W3=0.75, E3=zero (exception 00) -> wr_data=0.75 unchanged; updated_count=3.
- start pulsed again in cycle 3 -> ignored, exactly 4 writes occur. rst asserted in cycle 4 -> all outputs return to reset values, with no further wr_en and no done.
- MANHATTAN_CLAMP_EN, WEIGHT_LIMIT=1.0, W=0.75, eta=0.5, E=+1.0 -> wr_data=1.0. With W=-0.75 and E=-1.0 -> wr_data=-1.0.
